// File: rtl/start_screen_anim_if.sv
// Pixel-stream and button bundle between the OLED driver side and the
// start-screen animation block.
interface start_screen_anim_if;
    logic        frame_begin;
    logic [6:0]  x;
    logic [5:0]  y;
    logic        text_on;
    logic [1:0]  text_region;
    logic        btn_left;
    logic        btn_right;
    logic        btn_centre;
    logic [15:0] pixel_data;
    logic [2:0]  selected_wire;
    logic        burning;
    logic        start_game;

    // Driver / glyph / button side
    modport master (
        output frame_begin, x, y, text_on, text_region,
        output btn_left, btn_right, btn_centre,
        input  pixel_data, selected_wire, burning, start_game
    );

    // Animation block side
    modport slave (
        input  frame_begin, x, y, text_on, text_region,
        input  btn_left, btn_right, btn_centre,
        output pixel_data, selected_wire, burning, start_game
    );
endinterface

// File: rtl/start_screen_anim.sv
// Animated start screen: N coloured fuse wires, a selection cursor, a
// blinking "GO" and a top-to-bottom burn of the chosen wire that ends in
// a single start_game pulse. Pixel output is registered (1-cycle latency).
module start_screen_anim #(
    parameter int WIDTH            = 96,
    parameter int HEIGHT           = 64,
    parameter int NUM_WIRES        = 5,
    parameter int WIRE_X0          = 3,
    parameter int WIRE_PITCH       = 6,
    parameter int WIRE_W           = 2,
    parameter int BLINK_FRAMES     = 30,
    parameter int BURN_STEP_FRAMES = 2
) (
    input  logic                clk,
    input  logic                reset,
    start_screen_anim_if.slave  bus
);
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int STEP_W  = (BURN_STEP_FRAMES > 1) ? $clog2(BURN_STEP_FRAMES) : 1;
    localparam int ROW_W   = $clog2(HEIGHT + 1);

    localparam logic [15:0] C_BLACK = 16'h0000;
    localparam logic [15:0] C_WHITE = 16'hFFFF;
    localparam logic [15:0] C_EMBER = 16'hFFE0;

    typedef enum logic [1:0] {IDLE, BURN, DONE} state_t;

    state_t               state_reg, state_next;
    logic [2:0]           sel_reg, sel_next;
    logic                 blink_phase_reg, blink_phase_next;
    logic [BLINK_W-1:0]   blink_cnt_reg, blink_cnt_next;
    logic [ROW_W-1:0]     burn_row_reg, burn_row_next;
    logic [STEP_W-1:0]    step_cnt_reg, step_cnt_next;
    logic                 start_reg, start_next;
    logic [15:0]          pixel_reg, pixel_next;

    // Per-wire geometry decode
    logic [NUM_WIRES-1:0] wire_hit;
    logic [NUM_WIRES-1:0] sel_mask;
    logic [15:0]          wire_color [NUM_WIRES];

    generate
        for (genvar gi = 0; gi < NUM_WIRES; gi++) begin : g_wire
            localparam int LO = WIRE_X0 + gi * WIRE_PITCH;
            localparam int HI = LO + WIRE_W - 1;
            localparam logic [15:0] COL =
                ((gi % 5) == 0) ? 16'hFC0D :
                ((gi % 5) == 1) ? 16'hF800 :
                ((gi % 5) == 2) ? 16'h001F :
                ((gi % 5) == 3) ? 16'hFD20 : 16'h07E0;
            // Columns beyond the right edge never match, which clips the wire.
            assign wire_hit[gi]   = (int'(bus.x) >= LO) && (int'(bus.x) <= HI) &&
                                    (int'(bus.x) < WIDTH);
            assign sel_mask[gi]   = (sel_reg == 3'(gi));
            assign wire_color[gi] = COL;
        end
    endgenerate

    // Control state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            sel_reg         <= '0;
            blink_phase_reg <= 1'b1;
            blink_cnt_reg   <= '0;
            burn_row_reg    <= '0;
            step_cnt_reg    <= '0;
            start_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            sel_reg         <= sel_next;
            blink_phase_reg <= blink_phase_next;
            blink_cnt_reg   <= blink_cnt_next;
            burn_row_reg    <= burn_row_next;
            step_cnt_reg    <= step_cnt_next;
            start_reg       <= start_next;
        end
    end

    // Next-state: cursor moves, blink timing and burn progression
    always_comb begin
        state_next       = state_reg;
        sel_next         = sel_reg;
        blink_phase_next = blink_phase_reg;
        blink_cnt_next   = blink_cnt_reg;
        burn_row_next    = burn_row_reg;
        step_cnt_next    = step_cnt_reg;
        start_next       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.frame_begin) begin
                    if (blink_cnt_reg == BLINK_W'(BLINK_FRAMES - 1)) begin
                        blink_cnt_next   = '0;
                        blink_phase_next = ~blink_phase_reg;
                    end else begin
                        blink_cnt_next = blink_cnt_reg + 1'b1;
                    end
                end
                // Centre wins over a simultaneous left/right; opposing
                // left+right cancel out.
                if (bus.btn_centre) begin
                    state_next    = BURN;
                    burn_row_next = '0;
                    step_cnt_next = '0;
                end else if (bus.btn_left && !bus.btn_right) begin
                    sel_next = (sel_reg == 3'd0) ? 3'(NUM_WIRES - 1) : sel_reg - 3'd1;
                end else if (bus.btn_right && !bus.btn_left) begin
                    sel_next = (sel_reg == 3'(NUM_WIRES - 1)) ? 3'd0 : sel_reg + 3'd1;
                end
            end
            BURN: begin
                if (bus.frame_begin) begin
                    if (step_cnt_reg == STEP_W'(BURN_STEP_FRAMES - 1)) begin
                        step_cnt_next = '0;
                        // The row after the last one ends the burn instead.
                        if (burn_row_reg == ROW_W'(HEIGHT - 1)) begin
                            state_next = DONE;
                            start_next = 1'b1;
                        end else begin
                            burn_row_next = burn_row_reg + 1'b1;
                        end
                    end else begin
                        step_cnt_next = step_cnt_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    int          sel_x;
    logic        sel_hit;
    logic        text_vis;
    logic        ember_hit;
    logic        burnt_hit;
    logic        cursor_hit;
    logic [15:0] wire_col;

    // Pixel layering: text, ember, cursor, wire, black background
    always_comb begin
        sel_x    = WIRE_X0 + int'(sel_reg) * WIRE_PITCH;
        sel_hit  = |(wire_hit & sel_mask);
        // A hidden "GO" glyph is transparent, not black.
        text_vis = bus.text_on &&
                   !(bus.text_region == 2'd1 && state_reg == IDLE && !blink_phase_reg);
        ember_hit  = (state_reg == BURN) && sel_hit &&
                     (int'(bus.y) == int'(burn_row_reg));
        burnt_hit  = sel_hit && (((state_reg == BURN) && (int'(bus.y) < int'(burn_row_reg))) ||
                                 (state_reg == DONE));
        cursor_hit = (state_reg == IDLE) && (int'(bus.y) == HEIGHT - 1) &&
                     (int'(bus.x) >= sel_x - 1) && (int'(bus.x) <= sel_x + WIRE_W);
        wire_col = C_BLACK;
        for (int k = NUM_WIRES - 1; k >= 0; k--) begin
            if (wire_hit[k]) begin
                wire_col = wire_color[k];
            end
        end
        pixel_next = C_BLACK;
        if (text_vis) begin
            pixel_next = (bus.text_region == 2'd3) ? C_BLACK : C_WHITE;
        end else if (ember_hit) begin
            pixel_next = C_EMBER;
        end else if (cursor_hit) begin
            pixel_next = C_WHITE;
        end else if (|wire_hit) begin
            pixel_next = burnt_hit ? C_BLACK : wire_col;
        end
    end

    // Registered pixel output
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_reg <= '0;
        end else begin
            pixel_reg <= pixel_next;
        end
    end

    assign bus.pixel_data    = pixel_reg;
    assign bus.selected_wire = sel_reg;
    assign bus.burning       = (state_reg == BURN);
    assign bus.start_game    = start_reg;
endmodule

// File: tb/tb_start_screen_anim.sv
// Bench for start_screen_anim: random and directed stimulus checked each
// cycle against a frame-counting reference model of the start screen.
module tb_start_screen_anim;
    localparam int WIDTH            = 96;
    localparam int HEIGHT           = 64;
    localparam int NUM_WIRES        = 5;
    localparam int WIRE_X0          = 3;
    localparam int WIRE_PITCH       = 6;
    localparam int WIRE_W           = 2;
    localparam int BLINK_FRAMES     = 30;
    localparam int BURN_STEP_FRAMES = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    start_screen_anim_if bus ();

    start_screen_anim #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .NUM_WIRES(NUM_WIRES),
        .WIRE_X0(WIRE_X0), .WIRE_PITCH(WIRE_PITCH), .WIRE_W(WIRE_W),
        .BLINK_FRAMES(BLINK_FRAMES), .BURN_STEP_FRAMES(BURN_STEP_FRAMES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: phase 0 = choosing, 1 = burning, 2 = finished.
    int          m_phase;
    int          m_sel;
    int          m_idle_frames;   // frames seen while choosing, mod 2*BLINK_FRAMES
    int          m_burn_frames;   // frames seen since the burn was lit
    logic [15:0] m_pix;
    bit          m_start;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [15:0] palette(input int k);
        case (k % 5)
            0: return 16'hFC0D;
            1: return 16'hF800;
            2: return 16'h001F;
            3: return 16'hFD20;
            default: return 16'h07E0;
        endcase
    endfunction

    function automatic logic [15:0] ref_pixel(input int px, input int py, input bit ton, input int rg);
        int w = -1;
        int row = m_burn_frames / BURN_STEP_FRAMES;
        bit go_shown = (m_idle_frames < BLINK_FRAMES);
        int cx = WIRE_X0 + m_sel * WIRE_PITCH;
        if (ton) begin
            if (rg == 3) return 16'h0000;
            if (!(rg == 1 && m_phase == 0 && !go_shown)) return 16'hFFFF;
        end
        for (int k = 0; k < NUM_WIRES; k++) begin
            int lo = WIRE_X0 + k * WIRE_PITCH;
            if (px >= lo && px < lo + WIRE_W && px < WIDTH) w = k;
        end
        if (m_phase == 1 && w == m_sel && py == row) return 16'hFFE0;
        if (m_phase == 0 && py == HEIGHT - 1 && px >= cx - 1 && px <= cx + WIRE_W) return 16'hFFFF;
        if (w >= 0) begin
            if (w == m_sel && ((m_phase == 1 && py < row) || m_phase == 2)) return 16'h0000;
            return palette(w);
        end
        return 16'h0000;
    endfunction

    // One clock: drive inputs, advance the model, then compare all outputs.
    task automatic cycle(input bit rst, input bit fb, input bit l, input bit r, input bit c,
                         input int px, input int py, input bit ton, input int rg);
        reset             = rst;
        bus.frame_begin   = fb;
        bus.btn_left      = l;
        bus.btn_right     = r;
        bus.btn_centre    = c;
        bus.x             = 7'(px);
        bus.y             = 6'(py);
        bus.text_on       = ton;
        bus.text_region   = 2'(rg);
        if (rst) begin
            m_phase = 0; m_sel = 0; m_idle_frames = 0; m_burn_frames = 0;
            m_pix = 16'h0000; m_start = 1'b0;
        end else begin
            m_pix   = ref_pixel(px, py, ton, rg);
            m_start = 1'b0;
            if (m_phase == 0) begin
                if (fb) m_idle_frames = (m_idle_frames + 1) % (2 * BLINK_FRAMES);
                if (c) begin
                    m_phase = 1;
                    m_burn_frames = 0;
                end else if (l && !r) m_sel = (m_sel + NUM_WIRES - 1) % NUM_WIRES;
                else if (r && !l) m_sel = (m_sel + 1) % NUM_WIRES;
            end else if (m_phase == 1) begin
                if (fb) begin
                    m_burn_frames++;
                    if (m_burn_frames == HEIGHT * BURN_STEP_FRAMES) begin
                        m_phase = 2;
                        m_start = 1'b1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        $display("t=%0t rst=%0b fb=%0b l=%0b r=%0b c=%0b x=%0d y=%0d ton=%0b rg=%0d -> pix=%h sel=%0d burning=%0b start=%0b",
                 $time, rst, fb, l, r, c, px, py, ton, rg, bus.pixel_data, bus.selected_wire,
                 bus.burning, bus.start_game);
        check("pixel", bus.pixel_data, m_pix);
        check("selected_wire", 16'(bus.selected_wire), 16'(m_sel));
        check("burning", 16'(bus.burning), 16'(m_phase == 1));
        check("start_game", 16'(bus.start_game), 16'(m_start));
    endtask

    task automatic probe(input int px, input int py);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, px, py, 1'b0, 0);
    endtask

    // Random cycle: random pixel probe, optional buttons, frame_begin at fb_pct%.
    task automatic rnd_cycle(input bit allow_centre, input int fb_pct);
        int px = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 35)) : int'($urandom_range(0, 95));
        int py = ($urandom_range(0, 7) == 0) ? HEIGHT - 1 : int'($urandom_range(0, HEIGHT - 1));
        bit fb = (int'($urandom_range(0, 99)) < fb_pct);
        bit l  = ($urandom_range(0, 3) == 0);
        bit r  = ($urandom_range(0, 3) == 0);
        bit c  = allow_centre && ($urandom_range(0, 5) == 0);
        bit ton = ($urandom_range(0, 3) == 0);
        cycle(1'b0, fb, l, r, c, px, py, ton, int'($urandom_range(0, 3)));
    endtask

    task automatic move_to(input int target);
        for (int i = 0; i < 8 && m_sel != target; i++)
            cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 40, 30, 1'b0, 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.frame_begin = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_centre = 1'b0;
        bus.x = '0; bus.y = '0; bus.text_on = 1'b0; bus.text_region = '0;

        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
        check("rst_pixel", bus.pixel_data, 16'h0000);
        check("rst_sel", 16'(bus.selected_wire), 16'h0000);
        check("rst_burning", 16'(bus.burning), 16'h0000);

        // Wire colours
        probe(3, 10);  check("wire0_x3", bus.pixel_data, 16'hFC0D);
        probe(9, 10);  check("wire1_x9", bus.pixel_data, 16'hF800);
        probe(30, 10); check("bg_x30", bus.pixel_data, 16'h0000);

        // Cursor navigation
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 40, 30, 1'b0, 0);
            check("left_step", 16'(bus.selected_wire), 16'(4 - i));
        end
        move_to(4);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 40, 30, 1'b0, 0);
        check("right_wrap", 16'(bus.selected_wire), 16'h0000);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 40, 30, 1'b0, 0);
        check("left_right_cancel", 16'(bus.selected_wire), 16'h0000);

        // "GO" blink across 60 frames, title stays solid
        for (int i = 0; i < 2 * BLINK_FRAMES; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 60, 40, 1'b1, 1);
            check("go_blink", bus.pixel_data, (i < BLINK_FRAMES) ? 16'hFFFF : 16'h0000);
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 60, 20, 1'b1, 0);
            check("title_solid", bus.pixel_data, 16'hFFFF);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 60, 40, 1'b1, 1);
        check("go_back_on", bus.pixel_data, 16'hFFFF);

        // Random exploration while choosing
        repeat (300) rnd_cycle(1'b0, 10);

        // Cursor geometry
        move_to(1);
        probe(8, 63); check("cursor_on", bus.pixel_data, 16'hFFFF);
        probe(8, 62); check("cursor_off", bus.pixel_data, 16'h0000);

        // Light wire 2 and burn it
        move_to(2);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 40, 30, 1'b0, 0);
        check("burn_started", 16'(bus.burning), 16'h0001);
        repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 40, 30, 1'b0, 0);
        probe(15, 0); check("burnt_row0", bus.pixel_data, 16'h0000);
        probe(15, 1); check("ember_row1", bus.pixel_data, 16'hFFE0);
        for (int f = 2; f < HEIGHT * BURN_STEP_FRAMES; f++) begin
            int gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) rnd_cycle(1'b1, 0);
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 15, int'($urandom_range(0, 63)), 1'b0, 0);
        end
        check("start_pulse", 16'(bus.start_game), 16'h0001);
        check("burn_ended", 16'(bus.burning), 16'h0000);
        probe(15, 63); check("done_sel_black", bus.pixel_data, 16'h0000);
        check("start_one_cycle", 16'(bus.start_game), 16'h0000);
        probe(9, 63);  check("done_other_wire", bus.pixel_data, 16'hF800);
        repeat (50) rnd_cycle(1'b1, 20);

        // Reset in the middle of a burn
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 40, 30, 1'b0, 0);
        repeat (20 * BURN_STEP_FRAMES) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 40, 30, 1'b0, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 40, 30, 1'b0, 0);
        probe(3, 20); check("ember_row20", bus.pixel_data, 16'hFFE0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 20, 1'b0, 0);
        check("mid_reset_idle", 16'(bus.burning), 16'h0000);
        check("mid_reset_sel", 16'(bus.selected_wire), 16'h0000);
        check("mid_reset_nostart", 16'(bus.start_game), 16'h0000);
        repeat (10) rnd_cycle(1'b0, 30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
